// File: rtl/channel_cleaner.sv
// channel_cleaner: receive-side conditioner between the channel model and the
// FSK demodulator. Each of the two signed sample streams is smoothed by an
// N = 2**WIN_LOG2 sliding-window moving average. The window lives in a
// circular buffer, and the sum is updated by adding the new sample and
// subtracting the oldest one.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous clear of window, sums and counters
//   in_valid          input_1/input_2 carry a new sample
//   input_1/input_2   signed noisy samples
//   out_valid         1-cycle pulse, output_1/output_2 hold a new average
//   output_1/output_2 signed averaged samples (floor of sum / N)
//   window_full       N samples accepted since reset/flush
//   clamp_hit         sticky "a sample was saturated" flag; present only
//                     when CHANNEL_CLEANER_CLAMP_EN is defined
//
// Build option: `define CHANNEL_CLEANER_CLAMP_EN to saturate every input
// sample to [-CLAMP_MAX, +CLAMP_MAX] before it enters the window.

// Per-channel window storage, running sum and output register.
module channel_cleaner_lane #(
    parameter int DATA_W    = 16,
    parameter int WIN_LOG2  = 3,
    parameter int CLAMP_MAX = 28000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     acc_i,     // sample accepted this cycle
    input  logic                     fire_i,    // accepted sample completes a window
    input  logic [WIN_LOG2-1:0]      wr_ptr_i,
    input  logic signed [DATA_W-1:0] smp_i,
    output logic signed [DATA_W-1:0] avg_o
`ifdef CHANNEL_CLEANER_CLAMP_EN
    ,
    output logic                     clamp_o
`endif
);
    localparam int N  = 1 << WIN_LOG2;
    localparam int SW = DATA_W + WIN_LOG2;

    logic signed [DATA_W-1:0] buf_q [N];
    logic signed [SW-1:0]     sum_q, sum_d;
    logic signed [DATA_W-1:0] avg_q, avg_d;
    logic signed [DATA_W-1:0] x, oldest;

`ifdef CHANNEL_CLEANER_CLAMP_EN
    localparam logic signed [DATA_W-1:0] HI = DATA_W'(CLAMP_MAX);
    localparam logic signed [DATA_W-1:0] LO = DATA_W'(-CLAMP_MAX);

    always_comb begin
        x       = smp_i;
        clamp_o = 1'b0;
        if (smp_i > HI) begin
            x       = HI;
            clamp_o = 1'b1;
        end else if (smp_i < LO) begin
            x       = LO;
            clamp_o = 1'b1;
        end
    end
`else
    assign x = smp_i;
`endif

    // Slots not yet written hold 0 after reset/flush, so the fill phase
    // needs no special case.
    always_comb begin
        oldest = buf_q[wr_ptr_i];
        sum_d  = sum_q + $signed({{WIN_LOG2{x[DATA_W-1]}}, x})
                       - $signed({{WIN_LOG2{oldest[DATA_W-1]}}, oldest});
        // The arithmetic shift rounds toward minus infinity. The window
        // average always fits back into DATA_W.
        avg_d  = DATA_W'(sum_d >>> WIN_LOG2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
            sum_q <= '0;
            avg_q <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
            sum_q <= '0;
            avg_q <= '0;
        end else if (acc_i) begin
            buf_q[wr_ptr_i] <= x;
            sum_q           <= sum_d;
            if (fire_i) avg_q <= avg_d;
        end
    end

    assign avg_o = avg_q;
endmodule

module channel_cleaner #(
    parameter int DATA_W    = 16,
    parameter int WIN_LOG2  = 3,
    parameter int CLAMP_MAX = 28000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] input_1,
    input  logic signed [DATA_W-1:0] input_2,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] output_1,
    output logic signed [DATA_W-1:0] output_2,
    output logic                     window_full
`ifdef CHANNEL_CLEANER_CLAMP_EN
    ,
    output logic                     clamp_hit
`endif
);
    localparam int NUM_LANES = 2;
    localparam int N         = 1 << WIN_LOG2;
    localparam logic [WIN_LOG2:0] CNT_FULL = (WIN_LOG2+1)'(N);
    localparam logic [WIN_LOG2:0] CNT_LAST = (WIN_LOG2+1)'(N - 1);

    logic [NUM_LANES-1:0][DATA_W-1:0] in_pk, out_pk;
    logic [WIN_LOG2-1:0] wr_ptr_q;
    logic [WIN_LOG2:0]   cnt_q, cnt_d;
    logic                out_valid_q;
    logic                accept, fire;

    assign in_pk[0] = input_1;
    assign in_pk[1] = input_2;
    assign accept   = in_valid && !flush;
    // The counter saturates at N, so every accepted sample fires once the
    // window has been full since the previous sample.
    assign fire     = accept && (cnt_q >= CNT_LAST);
    assign cnt_d    = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;

`ifdef CHANNEL_CLEANER_CLAMP_EN
    logic [NUM_LANES-1:0] clamp_pk;
    logic                 clamp_hit_q;
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        channel_cleaner_lane #(
            .DATA_W    (DATA_W),
            .WIN_LOG2  (WIN_LOG2),
            .CLAMP_MAX (CLAMP_MAX)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .flush_i  (flush),
            .acc_i    (accept),
            .fire_i   (fire),
            .wr_ptr_i (wr_ptr_q),
            .smp_i    (in_pk[g]),
            .avg_o    (out_pk[g])
`ifdef CHANNEL_CLEANER_CLAMP_EN
            ,
            .clamp_o  (clamp_pk[g])
`endif
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= fire;
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;   // wraps N-1 -> 0
                cnt_q    <= cnt_d;
            end
        end
    end

`ifdef CHANNEL_CLEANER_CLAMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        clamp_hit_q <= 1'b0;
        else if (flush) clamp_hit_q <= 1'b0;
        else if (accept && |clamp_pk) clamp_hit_q <= 1'b1;
    end
    assign clamp_hit = clamp_hit_q;
`endif

    assign out_valid   = out_valid_q;
    assign output_1    = out_pk[0];
    assign output_2    = out_pk[1];
    assign window_full = (cnt_q == CNT_FULL);
endmodule

// File: tb/tb_channel_cleaner.sv
// Directed bench for channel_cleaner (N = 8). The expected values are hand
// computed. The clamp expectations follow CHANNEL_CLEANER_CLAMP_EN.
module tb_channel_cleaner;
    logic clk = 1'b0;
    logic rst, flush, in_valid;
    logic signed [15:0] input_1, input_2, output_1, output_2;
    logic out_valid, window_full;
`ifdef CHANNEL_CLEANER_CLAMP_EN
    logic clamp_hit;
`endif

    int tests = 0;
    int fails = 0;

    channel_cleaner dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .input_1     (input_1),
        .input_2     (input_2),
        .out_valid   (out_valid),
        .output_1    (output_1),
        .output_2    (output_2),
        .window_full (window_full)
`ifdef CHANNEL_CLEANER_CLAMP_EN
        ,
        .clamp_hit   (clamp_hit)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the capturing edge.
    task automatic cyc(input logic v, input int a, input int b, input logic f);
        in_valid = v;
        input_1  = 16'(a);
        input_2  = 16'(b);
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    function automatic int lim(input int v);
`ifdef CHANNEL_CLEANER_CLAMP_EN
        if (v > 28000)  return 28000;
        if (v < -28000) return -28000;
`endif
        return v;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; input_1 = '0; input_2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_output_1", output_1, 0);
        chk("rst_output_2", output_2, 0);
        chk("rst_window_full", 32'(window_full), 0);
        rst = 1'b0;

        // 1: constant fill
        for (int i = 0; i < 8; i++) begin
            cyc(1, 800, -800, 0);
            if (i < 7) begin
                chk("t1_no_valid", 32'(out_valid), 0);
                chk("t1_not_full", 32'(window_full), 0);
            end
        end
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_out1", output_1, 800);
        chk("t1_out2", output_2, -800);
        chk("t1_full", 32'(window_full), 1);
        cyc(0, 0, 0, 0);
        chk("t1_idle_valid", 32'(out_valid), 0);
        chk("t1_idle_hold", output_1, 800);

        // 2: wrap-around ramp
        cyc(0, 0, 0, 1);
        chk("t2_flush_full", 32'(window_full), 0);
        chk("t2_flush_out", output_1, 0);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
        chk("t2_prime_valid", 32'(out_valid), 1);
        for (int k = 1; k <= 10; k++) begin
            cyc(1, 80, -80, 0);
            chk("t2_ramp_valid", 32'(out_valid), 1);
            chk("t2_ramp_out1", output_1, (k < 8 ? k : 8) * 10);
            chk("t2_ramp_out2", output_2, -(k < 8 ? k : 8) * 10);
        end

        // 3: floor rounding and extremes
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0);
        cyc(1, -1, 0, 0);
        chk("t3_floor_out1", output_1, -1);
        chk("t3_floor_out2", output_2, 0);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(1, -32768, 32767, 0);
        chk("t3_min", output_1, lim(-32768));
        chk("t3_max", output_2, lim(32767));

        // 4: gapped in_valid
        cyc(0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            cyc(1, 400, 400, 0);
            chk("t4_valid", 32'(out_valid), (k == 7) ? 1 : 0);
            if (k < 7) begin
                cyc(0, 999, 999, 0);
                cyc(0, 999, 999, 0);
                chk("t4_idle_valid", 32'(out_valid), 0);
                chk("t4_idle_out", output_1, 0);
            end
        end
        chk("t4_out1", output_1, 400);
        cyc(0, 999, 999, 0);
        cyc(0, 999, 999, 0);
        chk("t4_hold_valid", 32'(out_valid), 0);
        chk("t4_hold_out", output_2, 400);
        chk("t4_hold_full", 32'(window_full), 1);

        // 5: flush with in_valid after full; then async reset mid-cycle
        cyc(1, 1234, 1234, 1);
        chk("t5_flush_full", 32'(window_full), 0);
        chk("t5_flush_out", output_1, 0);
        chk("t5_flush_valid", 32'(out_valid), 0);
        for (int i = 0; i < 7; i++) begin
            cyc(1, 100, 100, 0);
            chk("t5_refill_valid", 32'(out_valid), 0);
        end
        cyc(1, 100, 100, 0);
        chk("t5_refill_done", 32'(out_valid), 1);
        chk("t5_refill_out", output_1, 100);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("t5_arst_out1", output_1, 0);
        chk("t5_arst_out2", output_2, 0);
        chk("t5_arst_full", 32'(window_full), 0);
        #2 rst = 1'b0;
        for (int i = 0; i < 7; i++) cyc(1, 50, 50, 0);
        chk("t5_after_rst_wait", 32'(out_valid), 0);
        cyc(1, 50, 50, 0);
        chk("t5_after_rst_out", output_1, 50);

        // 6: clamp
        cyc(0, 0, 0, 1);
`ifdef CHANNEL_CLEANER_CLAMP_EN
        chk("t6_clamp_clear", 32'(clamp_hit), 0);
`endif
        for (int i = 0; i < 8; i++) cyc(1, 32000, -32000, 0);
        chk("t6_out1", output_1, lim(32000));
        chk("t6_out2", output_2, lim(-32000));
`ifdef CHANNEL_CLEANER_CLAMP_EN
        chk("t6_clamp_hit", 32'(clamp_hit), 1);
        cyc(0, 0, 0, 0);
        chk("t6_clamp_sticky", 32'(clamp_hit), 1);
        cyc(0, 0, 0, 1);
        chk("t6_clamp_flush", 32'(clamp_hit), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
